mux_rr_arbiter: RTL and testbench

Round-robin arbiter with an integrated registered 4:1 datapath mux. It shares one output stream between four valid/ready requester streams and drives the mux select internally. It sits in front of any single-consumer resource fed by four producers. The select is exported as sel_o for debug and downstream routing.

---
 rtl/mux_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter feeding a registered 4:1 data mux with a valid/ready output stage.
// Optional packet locking (grant held until a last beat) is enabled by MUX_RR_ARBITER_PKT_LOCK_EN.
module mux_rr_arbiter #(
  parameter int DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] data3_i,
  input  logic [3:0]        valid_i,
  output logic [3:0]        ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        sel_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  ,
  input  logic [3:0]        last_i,
  output logic              last_o
`endif
);

  // Returns {found, index} of the first requester after ptr, wrapping back to ptr itself last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + i[1:0];
      if (req[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        req_s;
  logic [2:0]        pick_s;
  logic              can_load_s;
  logic              xfer_s;
  logic [DATA_W-1:0] data_mux_s;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  logic              lock_q, lock_d;
  logic              last_q, last_d;
`endif

  // Grant selection, ready generation and next-state computation.
  always_comb begin
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    // While locked only the owner of the open packet (held in sel_q) may be granted.
    if (lock_q) begin
      req_s = valid_i & (4'b0001 << sel_q);
    end else begin
      req_s = valid_i;
    end
`else
    req_s = valid_i;
`endif
    pick_s     = rr_pick(req_s, ptr_q);
    can_load_s = !valid_q || ready_i;
    xfer_s     = pick_s[2] && can_load_s && rst_ni;
    if (xfer_s) begin
      ready_o = 4'b0001 << pick_s[1:0];
    end else begin
      ready_o = 4'b0000;
    end

    case (pick_s[1:0])
      2'd0:    data_mux_s = data0_i;
      2'd1:    data_mux_s = data1_i;
      2'd2:    data_mux_s = data2_i;
      2'd3:    data_mux_s = data3_i;
      default: data_mux_s = data0_i;
    endcase

    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    if (xfer_s) begin
      valid_d = 1'b1;
      data_d  = data_mux_s;
      sel_d   = pick_s[1:0];
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
      last_d  = last_i[pick_s[1:0]];
      lock_d  = !last_i[pick_s[1:0]];
      if (last_i[pick_s[1:0]]) begin
        ptr_d = pick_s[1:0];
      end else begin
        ptr_d = ptr_q;
      end
`else
      ptr_d   = pick_s[1:0];
`endif
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers; ptr resets to 3 so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  assign last_o  = last_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (lock scenario only when MUX_RR_ARBITER_PKT_LOCK_EN is defined).
module tb_mux_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] data0_i, data1_i, data2_i, data3_i;
  logic [3:0] valid_i;
  logic [3:0] ready_o;
  logic [1:0] data_o;
  logic [1:0] sel_o;
  logic       valid_o;
  logic       ready_i;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  logic [3:0] last_i;
  logic       last_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.DATA_W(2)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data0_i (data0_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .data3_i (data3_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    ,
    .last_i  (last_i),
    .last_o  (last_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [1:0] seq_a [4];
    seq_a = '{2'd1, 2'd3, 2'd1, 2'd3};
    rst_ni  = 1'b1;
    data0_i = 2'd0; data1_i = 2'd1; data2_i = 2'd2; data3_i = 2'd3;
    valid_i = 4'b1111;
    ready_i = 1'b1;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    last_i  = 4'b1111;
`endif
    #2 rst_ni = 1'b0;

    // Reset with all requesters valid and downstream ready.
    tick();
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o",  32'(data_o),  32'd0);
    chk("rst_sel_o",   32'(sel_o),   32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("first_ready_o", 32'(ready_o), 32'b0001);

    // Full rotation, one beat per cycle.
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rot_sel_o",   32'(sel_o),   32'(c % 4));
      chk("rot_data_o",  32'(data_o),  32'(c % 4));
      chk("rot_valid_o", 32'(valid_o), 32'd1);
    end

    // Single requester 2, back-to-back with changing data.
    for (int j = 0; j < 6; j++) begin
      valid_i = 4'b0100;
      data2_i = 2'(j);
      #1;
      chk("single_ready_o", 32'(ready_o), 32'b0100);
      tick();
      chk("single_sel_o",   32'(sel_o),   32'd2);
      chk("single_data_o",  32'(data_o),  32'(j % 4));
      chk("single_valid_o", 32'(valid_o), 32'd1);
    end
    data2_i = 2'd2;

    // Backpressure with requester 1's beat in the output register.
    valid_i = 4'b0010;
    tick();
    chk("bp_load_sel_o", 32'(sel_o), 32'd1);
    ready_i = 1'b0;
    valid_i = 4'b1111;
    #1;
    chk("bp_ready_o", 32'(ready_o), 32'd0);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bp_valid_o", 32'(valid_o), 32'd1);
      chk("bp_sel_o",   32'(sel_o),   32'd1);
      chk("bp_data_o",  32'(data_o),  32'd1);
      chk("bp_hold_ready_o", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready_o", 32'(ready_o), 32'b0100);
    tick();
    chk("bp_next_sel_o",  32'(sel_o),  32'd2);
    chk("bp_next_data_o", 32'(data_o), 32'd2);

    // No requests: output drains, data/sel hold, pointer unchanged.
    valid_i = 4'b0000;
    #1;
    chk("idle_ready_o", 32'(ready_o), 32'd0);
    tick();
    chk("idle_valid_o", 32'(valid_o), 32'd0);
    chk("idle_sel_o",   32'(sel_o),   32'd2);
    chk("idle_data_o",  32'(data_o),  32'd2);
    valid_i = 4'b1111;
    #1;
    chk("idle_ptr_ready_o", 32'(ready_o), 32'b1000);

    // Sparse requesters 1 and 3 from a fresh reset.
    rst_ni = 1'b0;
    valid_i = 4'b1010;
    #1;
    chk("rst2_valid_o", 32'(valid_o), 32'd0);
    chk("rst2_ready_o", 32'(ready_o), 32'd0);
    rst_ni = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("sparse_sel_o",  32'(sel_o),  32'(seq_a[j]));
      chk("sparse_data_o", 32'(data_o), 32'(seq_a[j]));
    end
    valid_i = 4'b0010;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("sparse1_sel_o",   32'(sel_o),   32'd1);
      chk("sparse1_valid_o", 32'(valid_o), 32'd1);
    end

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    // Requester 0 sends a three-beat packet while requester 1 waits.
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    valid_i = 4'b0011;
    last_i  = 4'b0000;
    tick();
    chk("lock_b0_sel_o",  32'(sel_o),  32'd0);
    chk("lock_b0_last_o", 32'(last_o), 32'd0);
    chk("lock_ready_o",   32'(ready_o), 32'b0001);
    tick();
    chk("lock_b1_sel_o",  32'(sel_o),  32'd0);
    chk("lock_b1_last_o", 32'(last_o), 32'd0);
    last_i = 4'b0001;
    tick();
    chk("lock_b2_sel_o",  32'(sel_o),  32'd0);
    chk("lock_b2_last_o", 32'(last_o), 32'd1);
    last_i = 4'b0000;
    #1;
    chk("unlock_ready_o", 32'(ready_o), 32'b0010);
    tick();
    chk("lock_b3_sel_o",  32'(sel_o),  32'd1);
    chk("lock_b3_last_o", 32'(last_o), 32'd0);
    chk("lock_b3_data_o", 32'(data_o), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
